// File: rtl/jackpot_game_ctrl.sv
// Jackpot board sequencer: synchronizes button/switches, paces a one-hot LED pointer
// and runs the IDLE/RUN/WIN/LOSE game flow with speed levels and miss tracking.
module jackpot_game_ctrl #(
  parameter int unsigned TICK_DIV   = 40000000,
  parameter int unsigned WIN_STEPS  = 4,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       BUTTON,
  input  logic [3:0] SWITCHES,
  output logic [3:0] LEDS,
  output logic [1:0] STATE,
  output logic [1:0] LEVEL,
  output logic       WIN_PULSE,
  output logic [2:0] MISSES
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WIN  = 2'b10,
    S_LOSE = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  btn_sync_q;
  logic        btn_prev_q;
  logic [3:0]  sw_s1_q, sw_s2_q, sw_prev_q;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  leds_q, leds_d;
  logic [1:0]  level_q, level_d;
  logic [2:0]  misses_q, misses_d;
  logic        pulse_q, pulse_d;
  logic [7:0]  wstep_q, wstep_d;

  logic        btn_rise;
  logic [3:0]  sw_rise;
  logic [31:0] period_m1;
  logic        step;

  assign btn_rise  = btn_sync_q[1] & ~btn_prev_q;
  assign sw_rise   = sw_s2_q & ~sw_prev_q;
  // Each level halves the step period.
  assign period_m1 = (32'(TICK_DIV) >> level_q) - 32'd1;
  assign step      = (state_q != S_IDLE) && (cnt_q == period_m1);

  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    level_d  = level_q;
    misses_d = misses_q;
    pulse_d  = 1'b0;
    wstep_d  = wstep_q;
    cnt_d    = step ? 32'd0 : cnt_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d  = 32'd0;
        leds_d = 4'b1000;
        if (btn_rise) begin
          state_d  = S_RUN;
          misses_d = 3'd0;
          level_d  = 2'd0;
        end
      end
      S_RUN: begin
        // Any switch activity is evaluated instead of rotating this cycle.
        if (sw_rise != 4'd0) begin
          if ((sw_rise == leds_q) && $onehot(sw_rise)) begin
            state_d = S_WIN;
            leds_d  = 4'b1111;
            pulse_d = 1'b1;
            wstep_d = 8'd0;
          end else begin
            misses_d = misses_q + 3'd1;
            if (misses_q + 3'd1 == 3'(MAX_MISSES)) begin
              state_d = S_LOSE;
              leds_d  = 4'b1010;
            end
          end
        end else if (step) begin
          leds_d = {leds_q[0], leds_q[3:1]};
        end
      end
      S_WIN: begin
        if (step) begin
          if (wstep_q == 8'(WIN_STEPS - 1)) begin
            state_d = S_RUN;
            leds_d  = 4'b1000;
            level_d = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
          end else begin
            wstep_d = wstep_q + 8'd1;
          end
        end
      end
      S_LOSE: begin
        if (btn_rise) begin
          state_d = S_IDLE;
          leds_d  = 4'b1000;
        end else if (step) begin
          leds_d = ~leds_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = 32'd0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      btn_sync_q <= 2'b00;
      btn_prev_q <= 1'b0;
      sw_s1_q    <= 4'd0;
      sw_s2_q    <= 4'd0;
      sw_prev_q  <= 4'd0;
      cnt_q      <= 32'd0;
      leds_q     <= 4'b1000;
      level_q    <= 2'd0;
      misses_q   <= 3'd0;
      pulse_q    <= 1'b0;
      wstep_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      btn_sync_q <= {btn_sync_q[0], BUTTON};
      btn_prev_q <= btn_sync_q[1];
      sw_s1_q    <= SWITCHES;
      sw_s2_q    <= sw_s1_q;
      sw_prev_q  <= sw_s2_q;
      cnt_q      <= cnt_d;
      leds_q     <= leds_d;
      level_q    <= level_d;
      misses_q   <= misses_d;
      pulse_q    <= pulse_d;
      wstep_q    <= wstep_d;
    end
  end

  assign LEDS      = leds_q;
  assign STATE     = state_q;
  assign LEVEL     = level_q;
  assign WIN_PULSE = pulse_q;
  assign MISSES    = misses_q;

endmodule

// File: tb/tb_jackpot_game_ctrl.sv
// Directed game scenarios plus random button/switch traffic, checked every cycle
// against a behavioural model of the game rules.
module tb_jackpot_game_ctrl;
  localparam int TD = 16;
  localparam int WS = 4;
  localparam int MM = 3;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       BUTTON = 1'b0;
  logic [3:0] SWITCHES = 4'd0;
  logic [3:0] LEDS;
  logic [1:0] STATE;
  logic [1:0] LEVEL;
  logic       WIN_PULSE;
  logic [2:0] MISSES;

  jackpot_game_ctrl #(.TICK_DIV(TD), .WIN_STEPS(WS), .MAX_MISSES(MM)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .BUTTON(BUTTON), .SWITCHES(SWITCHES),
    .LEDS(LEDS), .STATE(STATE), .LEVEL(LEVEL), .WIN_PULSE(WIN_PULSE), .MISSES(MISSES)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: input history gives the synchronized edge, age counts
  // cycles into the current step period.
  int         m_state, m_level, m_misses, m_age, m_wins;
  logic [3:0] m_leds;
  bit         m_pulse;
  bit         bh[3];
  logic [3:0] sh[3];

  always @(posedge CLOCK) begin : model
    bit         br;
    logic [3:0] sr;
    int         period, ns;
    bit         stp;
    if (RESET) begin
      m_state = 0; m_leds = 4'b1000; m_level = 0; m_misses = 0;
      m_pulse = 0; m_age = 0; m_wins = 0;
      for (int i = 0; i < 3; i++) begin bh[i] = 0; sh[i] = 4'd0; end
    end else begin
      br     = bh[1] && !bh[2];
      sr     = sh[1] & ~sh[2];
      period = TD >> m_level;
      stp    = (m_state != 0) && (m_age == period - 1);
      ns     = m_state;
      m_pulse = 0;
      case (m_state)
        0: if (br) begin ns = 1; m_misses = 0; m_level = 0; end
        1: begin
          if (sr != 0) begin
            if (sr == m_leds && $countones(sr) == 1) begin
              ns = 2; m_leds = 4'hF; m_pulse = 1; m_wins = 0;
            end else begin
              m_misses = m_misses + 1;
              if (m_misses == MM) begin ns = 3; m_leds = 4'b1010; end
            end
          end else if (stp) begin
            m_leds = 4'((m_leds >> 1) | (m_leds << 3));
          end
        end
        2: if (stp) begin
          m_wins = m_wins + 1;
          if (m_wins == WS) begin
            ns = 1; m_leds = 4'b1000;
            m_level = (m_level < 3) ? m_level + 1 : 3;
          end
        end
        default: begin
          if (br) begin ns = 0; m_leds = 4'b1000; end
          else if (stp) m_leds = 4'hF ^ m_leds;
        end
      endcase
      m_age   = (ns != m_state || ns == 0 || stp) ? 0 : m_age + 1;
      m_state = ns;
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = BUTTON;
      sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = SWITCHES;
    end
  end

  always @(negedge CLOCK) begin
    if (chk_en)
      chk("model", {20'd0, STATE, LEDS, LEVEL, WIN_PULSE, MISSES},
          {20'd0, m_state[1:0], m_leds, m_level[1:0], m_pulse, m_misses[2:0]});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic wait_state(input string nm, input logic [1:0] s, input int bound);
    int i = 0;
    while (STATE !== s && i < bound) begin @(negedge CLOCK); i++; end
    chk(nm, STATE, s);
  endtask

  // Wait for the pointer to freshly arrive at v.
  task automatic wait_enter(input string nm, input logic [3:0] v, input int bound);
    int i = 0;
    while (LEDS === v && i < bound) begin @(negedge CLOCK); i++; end
    while (LEDS !== v && i < bound) begin @(negedge CLOCK); i++; end
    chk(nm, LEDS, v);
  endtask

  // Leaves the bench just after the edge that evaluates the rise.
  task automatic sw_pulse(input logic [3:0] v);
    SWITCHES = v;
    tick(3);
  endtask

  task automatic sw_release();
    SWITCHES = 4'd0;
    tick(3);
  endtask

  function automatic logic [3:0] opposite(input logic [3:0] v);
    return {v[1:0], v[3:2]};
  endfunction

  function automatic logic [3:0] rotr(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  task automatic start_game();
    BUTTON = 1'b1;
    wait_state("start_run", 2'b01, 10);
    BUTTON = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0] v;
    int         i;
    tick(2);
    chk_en = 1'b1;
    chk("reset_state", STATE, 2'b00);
    chk("reset_leds", LEDS, 4'b1000);
    RESET = 1'b0;
    tick(3);

    // Pointer pacing at level 0
    start_game();
    chk("t1_leds0", LEDS, 4'b1000);
    tick(15); chk("t1_pre_step", LEDS, 4'b1000);
    tick(1);  chk("t1_step1", LEDS, 4'b0100);
    tick(32); chk("t1_step3", LEDS, 4'b0001);
    tick(16); chk("t1_wrap", LEDS, 4'b1000);

    // Win on 0010
    wait_enter("t2_at_0010", 4'b0010, 80);
    SWITCHES = 4'b0010;
    wait_state("t2_win", 2'b10, 8);
    chk("t2_pulse", WIN_PULSE, 1'b1);
    chk("t2_leds", LEDS, 4'hF);
    tick(1);  chk("t2_pulse_once", WIN_PULSE, 1'b0);
    tick(62); chk("t2_still_win", STATE, 2'b10);
    tick(1);
    chk("t2_back_run", STATE, 2'b01);
    chk("t2_level", LEVEL, 2'd1);
    chk("t2_leds_rst", LEDS, 4'b1000);
    SWITCHES = 4'd0;
    tick(7);  chk("t2_l1_pre", LEDS, 4'b1000);
    tick(1);  chk("t2_l1_step", LEDS, 4'b0100);

    // Three misses to LOSE
    sw_pulse(opposite(LEDS)); chk("t3_miss1", MISSES, 3'd1); sw_release();
    sw_pulse(opposite(LEDS)); chk("t3_miss2", MISSES, 3'd2); sw_release();
    sw_pulse(opposite(LEDS));
    chk("t3_lose", STATE, 2'b11);
    chk("t3_miss3", MISSES, 3'd3);
    chk("t3_lose_leds", LEDS, 4'b1010);
    SWITCHES = 4'd0;
    tick(7); chk("t3_hold", LEDS, 4'b1010);
    tick(1); chk("t3_toggle1", LEDS, 4'b0101);
    tick(8); chk("t3_toggle2", LEDS, 4'b1010);
    BUTTON = 1'b1;
    wait_state("t3_idle", 2'b00, 10);
    chk("t3_idle_leds", LEDS, 4'b1000);
    chk("t3_level_held", LEVEL, 2'd1);
    BUTTON = 1'b0;
    tick(3);

    // Held switch evaluates once; simultaneous rises are a miss
    start_game();
    wait_enter("t4_at_0001", 4'b0001, 80);
    SWITCHES = 4'b0100;
    tick(3);   chk("t4_one_miss", MISSES, 3'd1);
    tick(200); chk("t4_held", MISSES, 3'd1);
    SWITCHES = 4'd0;
    tick(3);
    wait_enter("t4_at_0100", 4'b0100, 80);
    sw_pulse(4'b0110);
    chk("t4_multi_miss", MISSES, 3'd2);
    chk("t4_multi_run", STATE, 2'b01);
    sw_release();

    // Hit coinciding with a step: WIN, no rotation
    wait_enter("t5_at_0001", 4'b0001, 80);
    tick(13);
    sw_pulse(4'b0001);
    chk("t5_win", STATE, 2'b10);
    chk("t5_no_rot", LEDS, 4'hF);
    wait_state("t5_run", 2'b01, 80);
    sw_release();
    for (int k = 0; k < 3; k++) begin
      i = 0;
      v = LEDS;
      while (LEDS === v && i < 40) begin @(negedge CLOCK); i++; end
      v = LEDS;
      SWITCHES = (LEVEL == 2'd3) ? rotr(v) : v;
      tick(3);
      chk("t5_win_k", STATE, 2'b10);
      wait_state("t5_run_k", 2'b01, 80);
      if (k < 2) sw_release();
    end
    chk("t5_level_sat", LEVEL, 2'd3);
    chk("t5_misses_kept", MISSES, 3'd2);
    chk("t5_entry_leds", LEDS, 4'b1000);
    SWITCHES = 4'd0;
    tick(1); chk("t5_p2_pre", LEDS, 4'b1000);
    tick(1); chk("t5_p2_step", LEDS, 4'b0100);
    tick(3);

    // Reset mid-WIN and mid-LOSE
    i = 0;
    v = LEDS;
    while (LEDS === v && i < 40) begin @(negedge CLOCK); i++; end
    v = LEDS;
    SWITCHES = rotr(v);
    tick(3);
    chk("t6_win", STATE, 2'b10);
    tick(2);
    RESET = 1'b1;
    tick(1);
    chk("t6_rst_win", {STATE, LEDS, LEVEL, WIN_PULSE, MISSES}, 12'b00_1000_00_0_000);
    RESET = 1'b0;
    SWITCHES = 4'd0;
    tick(3);
    start_game();
    for (int k = 0; k < 3; k++) begin sw_pulse(opposite(LEDS)); sw_release(); end
    chk("t6_lose", STATE, 2'b11);
    tick(5);
    RESET = 1'b1;
    tick(1);
    chk("t6_rst_lose", {STATE, LEDS, LEVEL, WIN_PULSE, MISSES}, 12'b00_1000_00_0_000);
    RESET = 1'b0;
    tick(3);

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      i = int'($urandom_range(0, 99));
      if (i < 3) BUTTON = ~BUTTON;
      i = int'($urandom_range(0, 99));
      if (i < 3)      SWITCHES = 4'd0;
      else if (i < 5) SWITCHES = LEDS;
      else if (i < 6) SWITCHES = 4'($urandom_range(0, 15));
      RESET = ($urandom_range(0, 1499) == 0);
      tick(1);
    end
    RESET = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
